uart_baud_gen: RTL and testbench



---
 rtl/uart_baud_gen.sv | 140 ++++++++++++++
 tb/tb_uart_baud_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//
// Fractional-accumulator baud tick generator for the UART TX/RX paths.
// An ACC_WIDTH-bit phase accumulator is advanced by an increment each enabled
// clock. Every carry out of the accumulator produces a one-cycle oversample
// tick (os_tick). Every OVERSAMPLE oversample ticks a bit tick (bit_tick)
// is produced, coincident with the os_tick that wraps os_cnt back to 0.
//
// The increment defaults to
//   DEFAULT_INC = round(BAUD_RATE * OVERSAMPLE * 2^ACC_WIDTH / CLK_FREQ)
//
// Optional feature macro: UART_BAUD_GEN_RUNTIME_INC_EN
//   defined   : the increment lives in a register that inc_load/inc_in can
//               reload at run time (a zero value is ignored).
//   undefined : the increment is the constant DEFAULT_INC; inc_load and
//               inc_in are accepted but unused.
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   en         in   advance the accumulator when high
//   restart    in   synchronous phase restart (clears acc and os_cnt)
//   half_phase in   with restart: start os_cnt at OVERSAMPLE/2
//   inc_load   in   load inc_in into the increment register
//   inc_in     in   new increment value (ACC_WIDTH bits)
//   os_tick    out  oversample tick, 1-cycle pulse (registered)
//   bit_tick   out  bit-period tick, 1-cycle pulse (registered)
//   os_cnt     out  current oversample phase ($clog2(OVERSAMPLE) bits)
// -----------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned ACC_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          en,
  input  logic                          restart,
  input  logic                          half_phase,
  input  logic                          inc_load,
  input  logic [ACC_WIDTH-1:0]          inc_in,
  output logic                          os_tick,
  output logic                          bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_cnt
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);

  // Rounded default increment, evaluated in 64-bit arithmetic.
  localparam longint unsigned DEFAULT_INC_64 =
    (64'(BAUD_RATE) * 64'(OVERSAMPLE) * (64'd1 << ACC_WIDTH) + 64'(CLK_FREQ) / 64'd2)
    / 64'(CLK_FREQ);

  localparam logic [ACC_WIDTH-1:0] DEFAULT_INC = DEFAULT_INC_64[ACC_WIDTH-1:0];
  localparam logic [CW-1:0]        OS_MAX      = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0]        OS_HALF     = CW'(OVERSAMPLE / 2);

  // Elaboration-time parameter checks.
  if (DEFAULT_INC_64 == 64'd0 || DEFAULT_INC_64 >= (64'd1 << ACC_WIDTH)) begin : g_inc_range_err
    $error("uart_baud_gen: DEFAULT_INC out of range for ACC_WIDTH");
  end

  if (OVERSAMPLE < 2 || OVERSAMPLE > 256 ||
      (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_oversample_err
    $error("uart_baud_gen: OVERSAMPLE must be a power of two in 2..256");
  end

  logic [ACC_WIDTH-1:0] r_acc;
  logic [CW-1:0]        r_os_cnt;
  logic                 r_os_tick;
  logic                 r_bit_tick;

  logic [ACC_WIDTH-1:0] w_inc;
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_carry;
  logic [CW-1:0]        w_os_cnt_nxt;

  // ---------------------------------------------------------------------------
  // Increment source
  // ---------------------------------------------------------------------------
`ifdef UART_BAUD_GEN_RUNTIME_INC_EN
  logic [ACC_WIDTH-1:0] r_inc;

  // Independent of en/restart; acc is untouched so a rate change causes no
  // phase jump. A zero increment would stall the generator, so it is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inc <= DEFAULT_INC;
    end else if (inc_load && (inc_in != '0)) begin
      r_inc <= inc_in;
    end
  end

  assign w_inc = r_inc;
`else
  logic w_unused_inc;

  assign w_inc        = DEFAULT_INC;
  assign w_unused_inc = ^{inc_load, inc_in};
`endif

  // ---------------------------------------------------------------------------
  // Accumulator and phase counter
  // ---------------------------------------------------------------------------
  assign w_sum        = {1'b0, r_acc} + {1'b0, w_inc};
  assign w_carry      = w_sum[ACC_WIDTH];
  assign w_os_cnt_nxt = (r_os_cnt == OS_MAX) ? '0 : r_os_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc      <= '0;
      r_os_cnt   <= '0;
      r_os_tick  <= 1'b0;
      r_bit_tick <= 1'b0;
    end else if (restart) begin
      // Restart wins over en and suppresses any carry on this edge.
      r_acc      <= '0;
      r_os_cnt   <= half_phase ? OS_HALF : '0;
      r_os_tick  <= 1'b0;
      r_bit_tick <= 1'b0;
    end else if (en) begin
      r_acc      <= w_sum[ACC_WIDTH-1:0];
      r_os_tick  <= w_carry;
      r_bit_tick <= w_carry && (r_os_cnt == OS_MAX);
      if (w_carry) begin
        r_os_cnt <= w_os_cnt_nxt;
      end
    end else begin
      r_os_tick  <= 1'b0;
      r_bit_tick <= 1'b0;
    end
  end

  assign os_tick  = r_os_tick;
  assign bit_tick = r_bit_tick;
  assign os_cnt   = r_os_cnt;

endmodule

// File: tb/tb_uart_baud_gen.sv
// -----------------------------------------------------------------------------
// tb_uart_baud_gen
//
// Directed bench for uart_baud_gen with CLK_FREQ=1600, BAUD_RATE=25,
// OVERSAMPLE=16, ACC_WIDTH=8 (DEFAULT_INC=64: one os_tick every 4 enabled
// edges, one bit_tick every 64). Inputs change and outputs are sampled on the
// falling clock edge; the DUT acts on the rising edge.
// Honours UART_BAUD_GEN_RUNTIME_INC_EN to select the expected increment-load
// behaviour.
// -----------------------------------------------------------------------------
module tb_uart_baud_gen;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       restart;
  logic       half_phase;
  logic       inc_load;
  logic [7:0] inc_in;
  logic       os_tick;
  logic       bit_tick;
  logic [3:0] os_cnt;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  uart_baud_gen #(
    .CLK_FREQ   (1600),
    .BAUD_RATE  (25),
    .OVERSAMPLE (16),
    .ACC_WIDTH  (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .restart    (restart),
    .half_phase (half_phase),
    .inc_load   (inc_load),
    .inc_in     (inc_in),
    .os_tick    (os_tick),
    .bit_tick   (bit_tick),
    .os_cnt     (os_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_os, input logic e_bit,
                          input logic [3:0] e_cnt);
    chk({tag, "_os"},  {31'd0, os_tick},  {31'd0, e_os});
    chk({tag, "_bit"}, {31'd0, bit_tick}, {31'd0, e_bit});
    chk({tag, "_cnt"}, {28'd0, os_cnt},   {28'd0, e_cnt});
  endtask

  // Enabled edges between os_ticks for the rate in force after loading 128.
`ifdef UART_BAUD_GEN_RUNTIME_INC_EN
  localparam int P128 = 2;
  localparam logic [15:0] PAT96 = 16'hA4A4;  // carries at edges 3,6,8,11,14,16
`else
  localparam int P128 = 4;
  localparam logic [15:0] PAT96 = 16'h8888;  // increment stays 64
`endif

  initial begin
    logic [3:0] exp_cnt;

    reset_n    = 1'b0;
    en         = 1'b0;
    restart    = 1'b0;
    half_phase = 1'b0;
    inc_load   = 1'b0;
    inc_in     = 8'd0;

    // Reset state
    #1;
    chk_outs("rst0", 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    chk_outs("rst1", 1'b0, 1'b0, 4'd0);

    // T1: free run from reset, 128 edges
    reset_n = 1'b1;
    en      = 1'b1;
    for (int j = 1; j <= 128; j++) begin
      @(negedge clk);
      chk_outs($sformatf("t1[%0d]", j), (j % 4) == 0, (j == 64) || (j == 128),
               4'((j / 4) % 16));
    end

    // T2: two edges (acc=128), then en low for 10 edges
    @(negedge clk);
    chk_outs("t2_e1", 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    chk_outs("t2_e2", 1'b0, 1'b0, 4'd0);
    en = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      chk_outs($sformatf("t2_hold[%0d]", j), 1'b0, 1'b0, 4'd0);
    end
    en = 1'b1;
    @(negedge clk);
    chk_outs("t2_re1", 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    chk_outs("t2_re2", 1'b1, 1'b0, 4'd1);

    // T3a: restart at half phase -> os_cnt=8, bit_tick after 32 edges
    restart    = 1'b1;
    half_phase = 1'b1;
    @(negedge clk);
    chk_outs("t3a_rs", 1'b0, 1'b0, 4'd8);
    restart    = 1'b0;
    half_phase = 1'b0;
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      chk_outs($sformatf("t3a[%0d]", j), (j % 4) == 0, j == 32, 4'((8 + j / 4) % 16));
    end

    // T3b: restart at full phase -> os_cnt=0, bit_tick after 64 edges
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    chk_outs("t3b_rs", 1'b0, 1'b0, 4'd0);
    restart = 1'b0;
    for (int j = 1; j <= 64; j++) begin
      @(negedge clk);
      chk_outs($sformatf("t3b[%0d]", j), (j % 4) == 0, j == 64, 4'((j / 4) % 16));
    end

    // T4a: load 128 together with restart (both take effect)
    restart  = 1'b1;
    inc_load = 1'b1;
    inc_in   = 8'd128;
    @(negedge clk);
    chk_outs("t4a_rs", 1'b0, 1'b0, 4'd0);
    restart  = 1'b0;
    inc_load = 1'b0;
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      chk_outs($sformatf("t4a[%0d]", j), (j % P128) == 0, j == 16 * P128,
               4'((j / P128) % 16));
    end

    // T4b: load 96 -> 3 os_ticks per 8 edges
    restart  = 1'b1;
    inc_load = 1'b1;
    inc_in   = 8'd96;
    @(negedge clk);
    chk_outs("t4b_rs", 1'b0, 1'b0, 4'd0);
    restart  = 1'b0;
    inc_load = 1'b0;
    exp_cnt  = 4'd0;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (PAT96[j-1]) exp_cnt = exp_cnt + 4'd1;
      chk_outs($sformatf("t4b[%0d]", j), PAT96[j-1], 1'b0, exp_cnt);
    end

    // T4c: load 0 is ignored, rate unchanged
    restart  = 1'b1;
    inc_load = 1'b1;
    inc_in   = 8'd0;
    @(negedge clk);
    chk_outs("t4c_rs", 1'b0, 1'b0, 4'd0);
    restart  = 1'b0;
    inc_load = 1'b0;
    exp_cnt  = 4'd0;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (PAT96[j-1]) exp_cnt = exp_cnt + 4'd1;
      chk_outs($sformatf("t4c[%0d]", j), PAT96[j-1], 1'b0, exp_cnt);
    end

    // T5: fresh reset, run to os_cnt=11, then async reset between edges
    reset_n = 1'b0;
    en      = 1'b0;
    @(negedge clk);
    chk_outs("t5_rst", 1'b0, 1'b0, 4'd0);
    reset_n = 1'b1;
    en      = 1'b1;
    for (int j = 1; j <= 44; j++) begin
      @(negedge clk);
      chk_outs($sformatf("t5a[%0d]", j), (j % 4) == 0, 1'b0, 4'((j / 4) % 16));
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk_outs("t5_async", 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // T6 setup: 63 edges from release (acc=192, os_cnt=15)
    for (int j = 1; j <= 63; j++) begin
      @(negedge clk);
      chk_outs($sformatf("t5b[%0d]", j), (j % 4) == 0, 1'b0, 4'((j / 4) % 16));
    end

    // T6: restart on the carry edge that would have produced bit_tick
    restart = 1'b1;
    @(negedge clk);
    chk_outs("t6_rs", 1'b0, 1'b0, 4'd0);
    restart = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      chk_outs($sformatf("t6[%0d]", j), j == 4, 1'b0, 4'(j / 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
